// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Purpose  : Instruction-memory and decode-side signal bundle of the fetch stage.
//  Revision : 1.0
// ============================================================================
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        fault;
    logic [31:0] retire_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr, op, funct3, funct7, pc, pc_plus4,
        input  pc_src, pc_target,
        output fault, retire_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr, op, funct3, funct7, pc, pc_plus4,
        output pc_src, pc_target,
        input  fault, retire_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : RV32 instruction fetch: PC, imem req/ack, held instr with valid/ready.
//  Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fetch_stage_if.master  bus
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retire;
    logic        r_fault;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_misaligned;
    logic        w_capture;
    logic        w_accept;
    logic        w_req;
    logic        w_valid;

    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        w_req        = 1'b0;
        w_valid      = 1'b0;
        w_pc_plus4   = r_pc + 32'd4;
        w_next_pc    = bus.pc_src ? bus.pc_target : w_pc_plus4;
        w_misaligned = |w_next_pc[1:0];
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                w_req = 1'b1;
                if (bus.imem_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_valid = 1'b1;
                if (bus.instr_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_misaligned ? S_HALT : S_REQ;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= C_NOP;
            r_retire <= 32'd0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_instr <= bus.imem_rdata;
            end
            if (w_accept) begin
                r_retire <= r_retire + 32'd1;
                // A misaligned target freezes the PC at the faulting instruction.
                if (w_misaligned) begin
                    r_fault <= 1'b1;
                end else begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    assign bus.imem_req     = w_req;
    assign bus.imem_addr    = r_pc;
    assign bus.instr_valid  = w_valid;
    assign bus.instr        = r_instr;
    assign bus.op           = r_instr[6:0];
    assign bus.funct3       = r_instr[14:12];
    assign bus.funct7       = r_instr[30];
    assign bus.pc           = r_pc;
    assign bus.pc_plus4     = w_pc_plus4;
    assign bus.fault        = r_fault;
    assign bus.retire_count = r_retire;

endmodule
`default_nettype wire
